// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared multiply/divide op encodings and operand helpers
package muldiv_seq_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;
  function automatic logic op_signed(md_op_e op);
    return ~op[0];
  endfunction
  function automatic logic op_div(md_op_e op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: core-side request, MTHI/MTLO and HI/LO result bundle
interface muldiv_seq_if import muldiv_seq_pkg::*; #(parameter int WIDTH = 32) ();
  logic start;
  md_op_e op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic hi_we;
  logic lo_we;
  logic [WIDTH-1:0] wdata;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave(input start, op, a, b, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring divide iteration
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] m,
  input  logic             div,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] sr_nx
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH-1:0] diff;
  logic ge;
  always_comb begin
    sum = {1'b0, acc} + (sr[0] ? {1'b0, m} : '0);
    shl = {acc, sr[WIDTH-1]};
    diff = shl[WIDTH-1:0] - m;
    ge = shl >= {1'b0, m};
    acc_nx = div ? (ge ? diff : shl[WIDTH-1:0]) : sum[WIDTH:1];
    sr_nx = div ? {sr[WIDTH-2:0], ge} : {sum[0], sr[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO
module muldiv_seq import muldiv_seq_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  muldiv_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_e;
  localparam int CW = $clog2(WIDTH);
  state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, acc, sr, m, acc_nx, sr_nx, hi_r, lo_r, quo, rem;
  logic [2*WIDTH-1:0] prod;
  md_op_e op_r;
  logic neg_q, neg_r, sgn, div;
  assign sgn = op_signed(op_r);
  assign div = op_div(op_r);
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .sr(sr), .m(m), .div(div), .acc_nx(acc_nx), .sr_nx(sr_nx)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (bus.start ? PREP : IDLE) :
               (state == PREP) ? RUN :
               (state == RUN)  ? (cnt == '0 ? FIX : RUN) :
               (state == FIX)  ? DONE : IDLE;
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.hi = hi_r;
    bus.lo = lo_r;
  end
  always_comb begin
    prod = neg_q ? -{acc, sr} : {acc, sr};
    quo = neg_q ? -sr : sr;
    rem = neg_r ? -acc : acc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      hi_r <= '0;
      lo_r <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      sr <= '0;
      m <= '0;
      op_r <= MD_MULT;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        a_r <= bus.a;
        b_r <= bus.b;
        op_r <= bus.op;
      end
      if (bus.hi_we) hi_r <= bus.wdata;
      if (bus.lo_we) lo_r <= bus.wdata;
    end else if (state == PREP) begin
      sr <= (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
      m <= (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
      acc <= '0;
      cnt <= CW'(WIDTH - 1);
      neg_q <= sgn && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
      neg_r <= sgn && a_r[WIDTH-1];
    end else if (state == RUN) begin
      acc <= acc_nx;
      sr <= sr_nx;
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      hi_r <= div ? (b_r == '0 ? a_r : rem) : prod[2*WIDTH-1:WIDTH];
      lo_r <= div ? (b_r == '0 ? '1 : quo) : prod[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq with hand-computed results
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int miss = 0;
  always #5 clk = ~clk;
  muldiv_seq_if #(.WIDTH(32)) bus ();
  muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input bit poke, input string tag);
    int k = 0;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy1"}, 32'(bus.busy), 32'd1);
      if (c == 10) begin
        check({tag, "_hi_hold"}, bus.hi, old_hi);
        check({tag, "_lo_hold"}, bus.lo, old_lo);
      end
      if (poke && c == 5) begin
        bus.start = 1'b1;
        bus.op = MD_DIVU;
        bus.a = 32'd9;
        bus.b = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hdead_beef;
      end
      if (poke && c == 6) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      if (bus.done) begin
        k = c;
        break;
      end
    end
    check({tag, "_done_cycle"}, 32'(k), 32'd35);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask
  initial begin
    int nd = 0;
    bus.start = 1'b0;
    bus.op = MD_MULT;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5678;
    check("mthi", bus.hi, 32'h0000_1234);
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo", bus.lo, 32'h0000_5678);
    run_op(MD_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001,
           32'h0000_1234, 32'h0000_5678, 1'b0, "multu_max");
    run_op(MD_MULT, -32'sd3, 32'd5, 32'hffff_ffff, 32'hffff_fff1,
           32'hffff_fffe, 32'h0000_0001, 1'b0, "mult_neg");
    run_op(MD_DIV, -32'sd7, 32'd2, 32'hffff_ffff, 32'hffff_fffd,
           32'hffff_ffff, 32'hffff_fff1, 1'b0, "div_neg");
    run_op(MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hffff_ffff,
           32'hffff_ffff, 32'hffff_fffd, 1'b0, "divu_zero");
    run_op(MD_DIV, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 32'h8000_0000,
           32'd100, 32'hffff_ffff, 1'b0, "div_ovf");
    bus.start = 1'b1;
    bus.op = MD_MULTU;
    bus.a = 32'd6;
    bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    check("abort_quiet", 32'(nd), 32'd0);
    run_op(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 32'd0, 1'b1, "mul67_poke");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the MIPS core; implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers. It runs an iterative shift-add / shift-subtract datapath for WIDTH steps while asserting `busy`, which the core uses to stall the PC and pipeline-free decode. HI/LO are also written directly by MTHI/MTLO and read by MFHI/MFLO through the `hi`/`lo` outputs.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch operation; sampled only when `busy`=0.
- op  in  2  operation select: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight; the core stalls while high.
- done  out  1  one-cycle pulse: HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE → PREP → RUN → FIX → DONE → IDLE.
- IDLE:
  - `start`=1 latches `a`, `b`, `op`, then goes to PREP.
  - `hi_we`/`lo_we` write `wdata` to HI/LO.
- PREP:
  - Signed ops: take absolute values of the operands.
  - Record result sign (mult: sign a ^ sign b) or quotient/remainder signs (div: sign a ^ sign b; sign a).
  - Clear accumulator; load iteration counter = WIDTH-1.
- RUN: one step per cycle, exactly WIDTH cycles; counter decrements; leaves on counter = 0.
  - Multiply: shift-add; 2·WIDTH product.
  - Divide: restoring; shift remainder left, trial subtract, quotient bit = no borrow.
- FIX:
  - Apply sign correction (two's-complement negate).
  - Write HI/LO: mult → HI = product[2W-1:W], LO = product[W-1:0]; div → LO = quotient, HI = remainder.
- DONE: `done`=1 for one cycle; returns to IDLE.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (b = 0, signed or unsigned): LO = all ones, HI = a; full latency still taken.
- Signed overflow (a = most-negative, b = −1): LO = a, HI = 0.
- `start` while `busy`=1: ignored; no queueing.
- `hi_we`/`lo_we` while `busy`=1: ignored.
- `start` with `hi_we`/`lo_we` in the same IDLE cycle: the write applies; the later result overwrites it.
- `rst` at any time, including mid-operation:
  - Next cycle: IDLE, `busy`=0, `done`=0, HI = LO = 0, counter = 0.
  - No `done` is produced for the aborted op.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0.
- `start` accepted at cycle edge 0 → `busy`=1 from cycle 1 (PREP) through cycle WIDTH+3 (DONE) inclusive.
- RUN occupies cycles 2..WIDTH+1; FIX is cycle WIDTH+2.
- `done` and the new HI/LO are visible in cycle WIDTH+3 (35 for WIDTH = 32).
- IDLE is re-entered in cycle WIDTH+4, where a new `start` is accepted; back-to-back throughput is one op per WIDTH+4 cycles.
- `hi`/`lo` are registered outputs.
  - Mid-operation they hold their previous values; intermediates stay internal.
  - MTHI/MTLO updates are visible the cycle after the write.
- `busy` is a registered state decode; it is not combinational from `start`.

## Structure
- The op encodings `MD_MULT`=2'b00, `MD_MULTU`=2'b01, `MD_DIV`=2'b10, `MD_DIVU`=2'b11 go in the shared `def.v` beside the ALU op codes.
- State encodings stay local.
- One combinational sub-module, `muldiv_step`.
  - Inputs: accumulator/remainder, shift register, operand, mode.
  - Outputs: the next values for one multiply or divide iteration.
- `muldiv_seq` owns the FSM, counter, sign logic and HI/LO registers.

## Test plan
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF:
  - `done` exactly in cycle 35 after `start`.
  - HI = 32'hFFFFFFFE, LO = 32'h00000001.
- MULT a=−3, b=5 → HI = 32'hFFFFFFFF, LO = 32'hFFFFFFF1.
- DIV a=−7, b=2 → LO = 32'hFFFFFFFD (−3), HI = 32'hFFFFFFFF (−1).
- DIVU a=100, b=0 → LO = 32'hFFFFFFFF, HI = 100.
- DIV a=32'h80000000, b=−1 → LO = 32'h80000000, HI = 0.
- Mid-op reset, then busy-time requests:
  - Start MULTU 6×7; assert `rst` in cycle 10 → `busy`=0 the next cycle, HI = LO = 0, no `done`.
  - Restart 6×7; pulse `start` (DIVU) and `hi_we` while busy → both ignored; result HI = 0, LO = 42.
